// File: rtl/fir_pkg.sv
// Shared state type, default sizes, accumulator sizing and the low-pass coefficient ROM
// for the bit-serial FIR filter.
package fir_pkg;

  localparam int unsigned DefDataWidth = 24;
  localparam int unsigned DefFirDepth  = 256;

  typedef enum logic [1:0] {StRx, StMac, StOutWait, StTx} fir_state_e;

  typedef logic [DefFirDepth-1:0][DefDataWidth-1:0] coeff_rom_t;

  function automatic int unsigned acc_width(input int unsigned data_width,
                                            input int unsigned depth);
    return 2 * data_width + $clog2(depth);
  endfunction

  // Symmetric triangular-window low-pass kernel; scale keeps sum|h| just below 1.0 in Q1.23.
  function automatic coeff_rom_t gen_coeffs();
    coeff_rom_t  rom;
    int unsigned half;
    int unsigned scale;
    int unsigned tap_w;
    rom   = '0;
    half  = DefFirDepth / 2;
    scale = ((1 << (DefDataWidth - 1)) - 1) / (half * (half + 1));
    for (int unsigned k = 0; k < DefFirDepth; k++) begin
      tap_w  = (k < half) ? k + 1 : DefFirDepth - k;
      rom[k] = DefDataWidth'(tap_w * scale);
    end
    return rom;
  endfunction

  localparam coeff_rom_t COEFFS = gen_coeffs();

endpackage

// File: rtl/fir_mac_engine.sv
// Delay-line RAM, coefficient ROM and sequential MAC with round-half-up output stage.
// Define FIR_SATURATE_EN to clamp out-of-range results instead of wrapping.
module fir_mac_engine
  import fir_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned FIR_DEPTH  = DefFirDepth
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] sample_i,
  output logic                  clearing_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int unsigned AddrW = $clog2(FIR_DEPTH);
  localparam int unsigned AccW  = acc_width(DATA_WIDTH, FIR_DEPTH);
  localparam logic [AddrW-1:0]       LastTap   = AddrW'(FIR_DEPTH - 1);
  localparam logic signed [AccW-1:0] RoundBias = AccW'(1) << (DATA_WIDTH - 2);

  logic [DATA_WIDTH-1:0]          ram_q [FIR_DEPTH];
  logic signed [DATA_WIDTH-1:0]   rd_q, coef_q;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [AccW-1:0]         acc_q;
  logic [AddrW-1:0]               wr_ptr_q, tap_q, clr_ptr_q, ram_waddr;
  logic [DATA_WIDTH-1:0]          ram_wdata;
  logic                           clr_q, run_q, prod_vld_q, last_q, done_q, ram_we;

  // The reset-time clear walk and sample writes share the single write port.
  assign ram_we    = en_i & ~rst_i & (clr_q | start_i);
  assign ram_waddr = clr_q ? clr_ptr_q : wr_ptr_q;
  assign ram_wdata = clr_q ? '0 : sample_i;

  always_ff @(posedge clk_i) begin
    if (ram_we) ram_q[ram_waddr] <= ram_wdata;
    if (en_i) begin
      rd_q   <= ram_q[wr_ptr_q - tap_q];
      coef_q <= DATA_WIDTH'(COEFFS[tap_q]);
    end
  end

  assign prod = $signed({{DATA_WIDTH{rd_q[DATA_WIDTH-1]}}, rd_q}) *
                $signed({{DATA_WIDTH{coef_q[DATA_WIDTH-1]}}, coef_q});

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clr_q      <= 1'b1;
      clr_ptr_q  <= '0;
      wr_ptr_q   <= '0;
      tap_q      <= '0;
      run_q      <= 1'b0;
      prod_vld_q <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      acc_q      <= '0;
    end else if (en_i) begin
      if (clr_q) begin
        clr_ptr_q <= clr_ptr_q + 1'b1;
        if (clr_ptr_q == LastTap) clr_q <= 1'b0;
      end
      // Two-stage pipe: address/ROM read, then accumulate.
      prod_vld_q <= run_q;
      last_q     <= run_q & (tap_q == LastTap);
      done_q     <= last_q;
      if (prod_vld_q) acc_q <= acc_q + AccW'(prod);
      if (last_q) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (start_i) begin
        run_q <= 1'b1;
        tap_q <= '0;
        acc_q <= '0;
      end else if (run_q) begin
        tap_q <= tap_q + 1'b1;
        if (tap_q == LastTap) run_q <= 1'b0;
      end
    end
  end

  assign clearing_o = clr_q;
  assign done_o     = done_q;

`ifdef FIR_SATURATE_EN
  logic signed [AccW-1:0] shifted;
  always_comb begin
    shifted = (acc_q + RoundBias) >>> (DATA_WIDTH - 1);
    if (shifted > $signed({{(AccW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}})) begin
      result_o = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (shifted < $signed({{(AccW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}})) begin
      result_o = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      result_o = shifted[DATA_WIDTH-1:0];
    end
  end
`else
  assign result_o = DATA_WIDTH'((acc_q + RoundBias) >>> (DATA_WIDTH - 1));
`endif

endmodule

// File: rtl/fir_top_level.sv
// Bit-serial FIR low-pass top: LSB-first deserialiser, MAC engine handoff and LSB-first
// serialiser under a ready/valid handshake.
module fir_top_level
  import fir_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned FIR_DEPTH  = DefFirDepth
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_din,
  input  logic i_din_valid,
  input  logic i_ready,
  output logic o_ready,
  output logic o_dout,
  output logic o_dout_valid
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

  fir_state_e            state_q, state_d;
  logic [DATA_WIDTH-2:0] rx_sr_q;
  logic [DATA_WIDTH-1:0] tx_sr_q, sample, result;
  logic [CntW-1:0]       rx_cnt_q, tx_cnt_q;
  logic                  dout_q, clearing, mac_done, rx_fire, rx_last, tx_fire;

  assign o_ready      = (state_q == StRx) & ~clearing;
  assign o_dout_valid = (state_q == StOutWait);
  assign o_dout       = dout_q;

  assign rx_fire = i_en & i_din_valid & o_ready;
  assign rx_last = rx_fire & (rx_cnt_q == LastBit);
  assign tx_fire = i_en & i_ready;
  // Final bit bypasses the shifter so the word reaches the delay line on the capture edge.
  assign sample  = {i_din, rx_sr_q};

  fir_mac_engine #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIR_DEPTH  (FIR_DEPTH)
  ) u_mac (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .en_i       (i_en),
    .start_i    (rx_last),
    .sample_i   (sample),
    .clearing_o (clearing),
    .done_o     (mac_done),
    .result_o   (result)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRx:      if (rx_last) state_d = StMac;
      StMac:     if (i_en && mac_done) state_d = StOutWait;
      StOutWait: if (tx_fire) state_d = StTx;
      StTx:      if (tx_fire && tx_cnt_q == LastBit) state_d = StRx;
      default:   state_d = StRx;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= StRx;
      rx_sr_q  <= '0;
      rx_cnt_q <= '0;
      tx_sr_q  <= '0;
      tx_cnt_q <= '0;
      dout_q   <= 1'b0;
    end else if (i_en) begin
      state_q <= state_d;
      if (rx_fire) begin
        rx_sr_q  <= {i_din, rx_sr_q[DATA_WIDTH-2:1]};
        rx_cnt_q <= rx_last ? '0 : rx_cnt_q + 1'b1;
      end
      if (state_q == StMac && mac_done) tx_sr_q <= result;
      if (tx_fire && state_q inside {StOutWait, StTx}) begin
        if (state_q == StTx && tx_cnt_q == LastBit) begin
          dout_q <= 1'b0;
        end else begin
          dout_q  <= tx_sr_q[0];
          tx_sr_q <= {1'b0, tx_sr_q[DATA_WIDTH-1:1]};
        end
        tx_cnt_q <= (state_q == StOutWait) ? '0 : tx_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_top_level.sv
// Scoreboard bench for fir_top_level: serial word driver, golden FIR model feeding an
// expected-word queue, and an independent sink/monitor that reassembles and compares words.
module tb_fir_top_level;
  import fir_pkg::*;

  localparam int unsigned DW    = DefDataWidth;
  localparam int unsigned Depth = DefFirDepth;

  logic tb_clk = 1'b0;
  logic i_rst, i_en, i_din, i_din_valid, i_ready;
  logic o_ready, o_dout, o_dout_valid;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            n_sent  = 0;
  int            n_words = 0;
  logic [DW-1:0] exp_q[$];
  longint        hist [Depth];
  int unsigned   hist_wp = 0;
  bit            sink_hold = 1'b0;
  bit            out_phase = 1'b0;

  always #5 tb_clk = ~tb_clk;

  fir_top_level dut (
    .i_clk        (tb_clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .i_din        (i_din),
    .i_din_valid  (i_din_valid),
    .i_ready      (i_ready),
    .o_ready      (o_ready),
    .o_dout       (o_dout),
    .o_dout_valid (o_dout_valid)
  );

  task automatic check(input string name, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] model_push(input logic [DW-1:0] x);
    longint acc = 0;
    longint y;
    hist[hist_wp] = longint'($signed(x));
    for (int k = 0; k < Depth; k++)
      acc += longint'($signed(COEFFS[k])) * hist[(hist_wp + Depth - k) % Depth];
    hist_wp = (hist_wp + 1) % Depth;
    y = (acc + (longint'(1) <<< (DW - 2))) >>> (DW - 1);
`ifdef FIR_SATURATE_EN
    if (y > (longint'(1) <<< (DW - 1)) - 1) y = (longint'(1) <<< (DW - 1)) - 1;
    else if (y < -(longint'(1) <<< (DW - 1))) y = -(longint'(1) <<< (DW - 1));
`endif
    return y[DW-1:0];
  endfunction

  task automatic clear_model();
    for (int k = 0; k < Depth; k++) hist[k] = 0;
    hist_wp = 0;
  endtask

  // Presents bits continuously; a bit counts as taken only when o_ready and i_en are high.
  task automatic send_word(input logic [DW-1:0] w, input bit en_gap);
    int k = 0;
    int guard = 0;
    int low = 0;
    exp_q.push_back(model_push(w));
    n_sent++;
    while (k < DW) begin
      @(negedge tb_clk);
      i_din       = w[k];
      i_din_valid = 1'b1;
      i_en        = !(en_gap && k == DW / 2 && low < 3);
      if (!i_en) low++;
      if (o_ready && i_en) k++;
      guard++;
      if (guard > 4000) begin
        check("send_timeout", k, DW);
        break;
      end
    end
    @(negedge tb_clk);
    i_din_valid = 1'b0;
    i_en        = 1'b1;
  endtask

  task automatic wait_ready(input string name);
    int cyc = 0;
    while (!o_ready && cyc < Depth + 1) begin
      @(negedge tb_clk);
      cyc++;
    end
    check(name, o_ready, 1);
  endtask

  task automatic drain();
    int cyc = 0;
    while ((exp_q.size() != 0 || out_phase) && cyc < 3000) begin
      @(negedge tb_clk);
      cyc++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  // Sink: accepts whenever allowed, counts accepting edges, rebuilds the word LSB first.
  initial begin : monitor
    int            n_acc = 0;
    logic [DW-1:0] word  = '0;
    bit            acc_edge;
    i_ready = 1'b0;
    forever begin
      @(posedge tb_clk);
      acc_edge = out_phase && i_en && i_ready;
      @(negedge tb_clk);
      if (acc_edge) begin
        n_acc++;
        if (n_acc == 1) check("valid_drop", o_dout_valid, 0);
        if (n_acc <= DW) word[n_acc-1] = o_dout;
        if (n_acc == DW) begin
          n_words++;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL extra_word: got 0x%0h, required no word", word);
          end else begin
            check($sformatf("word%0d", n_words), word, exp_q.pop_front());
          end
        end
        if (n_acc == DW + 1) begin
          check("dout_idle", o_dout, 0);
          n_acc     = 0;
          out_phase = 1'b0;
        end
      end
      if (!out_phase && o_dout_valid) out_phase = 1'b1;
      i_ready = out_phase && !sink_hold;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int lat;
    int held;
    int rdy_hi;
    real s;
    i_rst = 1'b1; i_en = 1'b1; i_din = 1'b0; i_din_valid = 1'b0;
    clear_model();

    // Reset state and clear walk
    repeat (3) @(negedge tb_clk);
    check("rst_ready", o_ready, 0);
    check("rst_valid", o_dout_valid, 0);
    check("rst_dout", o_dout, 0);
    i_rst = 1'b0;
    wait_ready("clear_done");
    check("idle_valid", o_dout_valid, 0);
    check("idle_dout", o_dout, 0);

    // Zero input
    repeat (5) send_word('0, 1'b0);

    // Impulse response
    send_word(24'h7FFFFF, 1'b0);
    repeat (31) send_word('0, 1'b0);
    drain();

    // Bit order after a fresh clear
    @(negedge tb_clk);
    i_rst = 1'b1;
    repeat (3) @(negedge tb_clk);
    i_rst = 1'b0;
    clear_model();
    wait_ready("clear_done2");
    send_word(24'h000001, 1'b0);
    send_word(24'h400000, 1'b0);
    drain();

    // Backpressure with junk input while output is pending
    sink_hold = 1'b1;
    send_word(24'h7FFFFF, 1'b0);
    lat = 0;
    while (!o_dout_valid && lat < Depth + 10) begin
      @(negedge tb_clk);
      lat++;
    end
    check("mac_latency_ok", (lat <= Depth + 3), 1);
    held = 0; rdy_hi = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge tb_clk);
      i_din       = 1'($urandom);
      i_din_valid = 1'b1;
      if (o_dout_valid) held++;
      if (o_ready) rdy_hi++;
    end
    check("bp_valid_held", held, 200);
    check("bp_ready_low", rdy_hi, 0);
    i_din_valid = 1'b0;
    sink_hold   = 1'b0;
    drain();

    // 200 Hz sine at 44 kHz with clock-enable gaps inside some words
    for (int n = 0; n < 60; n++) begin
      s = 4194304.0 * $sin(2.0 * 3.14159265358979 * 200.0 * n / 44000.0);
      send_word(DW'($rtoi($floor(s + 0.5))), (n % 7) == 3);
      repeat (50) @(negedge tb_clk);
    end
    drain();
    check("word_count", n_words, n_sent);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
